// File: rtl/serial_add_sub_ctrl.sv
// serial_add_sub_ctrl: bit-serial add/subtract sequencer, LSB first, driving one external
// 1-bit full-adder cell through the fa_* ports and collecting the sum into a result register.
module serial_add_sub_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             w_run;
    logic             w_last;
    logic [WIDTH-1:0] w_sh_next;

    assign w_run     = r_state == S_RUN;
    assign w_last    = r_cnt == CNT_W'(WIDTH - 1);
    assign w_sh_next = {fa_s, r_sh[WIDTH-1:1]};

    assign busy     = w_run;
    assign done     = r_state == S_DONE;
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;
    assign fa_a     = w_run ? r_a[0] : 1'b0;
    assign fa_b     = w_run ? r_b[0] : 1'b0;
    assign fa_cin   = w_run ? r_carry : 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_sh     <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_a     <= op_a;
                r_b     <= op_b ^ {WIDTH{sub}};
                r_carry <= sub;
                r_cnt   <= '0;
                r_state <= S_RUN;
            end
        end else if (w_run) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_sh    <= w_sh_next;
            r_carry <= fa_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            // On the MSB step the carry into the MSB is the current fa_cin
            if (w_last) begin
                r_result <= w_sh_next;
                r_cout   <= fa_cout;
                r_ovf    <= r_carry ^ fa_cout;
                r_state  <= S_DONE;
            end
        end else begin
            r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// tb_serial_add_sub_ctrl: directed and swept checks of the serial add/sub sequencer with
// behavioural full-adder cells on an 8-bit and a 32-bit instance.
module tb_serial_add_sub_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       start8 = 1'b0, sub8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, res8;
    logic       busy8, done8, cout8, ovf8, fa_a8, fa_b8, fa_cin8, fa_s8, fa_co8;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0, res32;
    logic        busy32, done32, cout32, ovf32, fa_a32, fa_b32, fa_cin32, fa_s32, fa_co32;

    assign fa_s8   = fa_a8 ^ fa_b8 ^ fa_cin8;
    assign fa_co8  = (fa_a8 & fa_b8) | (fa_cin8 & (fa_a8 ^ fa_b8));
    assign fa_s32  = fa_a32 ^ fa_b32 ^ fa_cin32;
    assign fa_co32 = (fa_a32 & fa_b32) | (fa_cin32 & (fa_a32 ^ fa_b32));

    serial_add_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .op_a(a8), .op_b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .overflow(ovf8),
        .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_s(fa_s8), .fa_cout(fa_co8)
    );

    serial_add_sub_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .sub(1'b0), .op_a(a32), .op_b(b32),
        .busy(busy32), .done(done32), .result(res32), .cout(cout32), .overflow(ovf32),
        .fa_a(fa_a32), .fa_b(fa_b32), .fa_cin(fa_cin32), .fa_s(fa_s32), .fa_cout(fa_co32)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] res;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs[5];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, independent of the serial datapath
    function automatic logic [9:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] bb;
        logic [8:0] sum;
        bb  = s ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {8'd0, s};
        return {sum[7:0], sum[8], (a[7] == bb[7]) && (sum[7] != a[7])};
    endfunction

    // Starts one 8-bit operation from IDLE and checks latency, busy span and the done pulse
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [9:0] exp, input string name, input bit timing);
        int lat;
        int bcnt;
        a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = ~a; b8 = ~b; sub8 = ~s;
        lat = 0; bcnt = 0;
        while (!done8 && lat < 100) begin
            if (busy8) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        check({name, " result"}, {res8, cout8, ovf8}, exp);
        if (timing) begin
            check({name, " latency"}, lat, 8);
            check({name, " busy cycles"}, bcnt, 8);
        end
        @(posedge clk); #1;
        if (timing) check({name, " done one cycle"}, done8, 0);
    endtask

    initial begin
        logic [7:0] ea, eb;
        logic       es;
        int         ndone;
        int         lat;
        vecs[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

        #2;
        check("reset outputs", {busy8, done8, res8, cout8, ovf8, fa_a8, fa_b8, fa_cin8}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i])
            run8(vecs[i].a, vecs[i].b, vecs[i].sub, {vecs[i].res, vecs[i].co, vecs[i].ov},
                 $sformatf("vec%0d", i), 1'b1);

        // Held start: accepted only in IDLE, once every WIDTH+2 cycles
        ndone = 0; ea = '0; eb = '0; es = 1'b0;
        start8 = 1'b1;
        for (int c = 0; c < 30; c++) begin
            a8 = 8'(c * 37 + 5); b8 = 8'(c * 11 + 3); sub8 = c[0];
            if (c % 10 == 0) begin ea = a8; eb = b8; es = sub8; end
            @(posedge clk); #1;
            check($sformatf("held c%0d busy", c), busy8, (c % 10) < 8);
            check($sformatf("held c%0d done", c), done8, (c % 10) == 8);
            if (done8) begin
                ndone++;
                check($sformatf("held c%0d result", c), {res8, cout8, ovf8}, ref8(ea, eb, es));
            end
        end
        start8 = 1'b0;
        check("held done count", ndone, 3);
        @(posedge clk); #1;

        // Reset in the 4th RUN cycle aborts without a done pulse
        a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre-abort busy", busy8, 1);
        rst = 1'b1;
        #1;
        check("abort outputs", {busy8, done8, res8, cout8, ovf8, fa_a8, fa_b8, fa_cin8}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        check("abort no done", ndone, 0);
        run8(8'h12, 8'h34, 1'b0, {8'h46, 1'b0, 1'b0}, "post-abort", 1'b1);

        for (int i = 0; i < 256; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            run8(ra, rb, 1'b0, ref8(ra, rb, 1'b0), $sformatf("sweep%0d add", i), 1'b0);
            run8(ra, rb, 1'b1, ref8(ra, rb, 1'b1), $sformatf("sweep%0d sub", i), 1'b0);
        end

        a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 0;
        while (!done32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w32 latency", lat, 32);
        check("w32 result", {res32, cout32, ovf32}, {32'h0, 1'b1, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
